// File: rtl/dct_mb_sched.sv
// ---------------------------------------------------------------------------
// dct_mb_sched
//
// Macroblock scheduler for one dct2d instance. A 4:2:0 macroblock holds six
// 8x8 blocks: 0..3 luma (tiled 2x2 over a 16x16 array) and 4..5 chroma.
// Blocks are visited in order 0..5 and a block whose mask bit is 0 is
// skipped. For each processed block, one dct2d run is launched. While it
// runs, the dct2d block-local addresses are translated into macroblock
// buffer addresses.
//
// Ports
//   clk, reset_n      clock, synchronous active-low reset
//   start, blk_mask   macroblock request; the mask is sampled with start
//   rdy, busy         idle / macroblock in progress
//   mb_done           one-cycle pulse when the macroblock is finished
//   blk_idx           block currently owned by dct2d
//   dct_rdy, dct_en   dct2d idle indication / per-block enable
//   dct_iaddr/maddr/waddr/wwren
//                     dct2d block-local addresses and write strobe
//   src_addr          source buffer address (384 words)
//   mat_addr          quantiser ROM address {chroma, dct_maddr}
//   dst_addr/dst_wren coefficient buffer address and write enable
//   dbg_state         current FSM state, for observation only
//
// Handshake with dct2d: dct_en is asserted only when dct_rdy is also high,
// so every cycle with dct_en=1 starts exactly one block. Completion is seen
// as dct_rdy falling (dct2d accepted the block) and then rising again.
// ---------------------------------------------------------------------------
module dct_mb_sched #(
    parameter int NBLK      = 6,
    parameter int LUMA_BLKS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [5:0] blk_mask,
    output logic       rdy,
    output logic       busy,
    output logic       mb_done,
    output logic [2:0] blk_idx,
    input  logic       dct_rdy,
    output logic       dct_en,
    input  logic [5:0] dct_iaddr,
    input  logic [5:0] dct_maddr,
    input  logic [5:0] dct_waddr,
    input  logic       dct_wwren,
    output logic [8:0] src_addr,
    output logic [6:0] mat_addr,
    output logic [8:0] dst_addr,
    output logic       dst_wren,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEEK      = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FIN       = 3'd5
    } state_t;

    localparam logic [2:0] LAST_BLK  = 3'(NBLK - 1);
    localparam logic [2:0] LUMA_LAST = 3'(LUMA_BLKS);

    state_t     state_q, state_d;
    logic [2:0] blk_q, blk_d;
    logic [5:0] mask_q, mask_d;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            blk_q   <= 3'd0;
            mask_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            mask_q  <= mask_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        mask_d  = mask_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d  = blk_mask;
                    blk_d   = 3'd0;
                    state_d = S_SEEK;
                end
            end
            S_SEEK: begin
                // One cycle per skipped block; the index stops at the last
                // block so it can never wrap.
                if (mask_q[blk_q]) begin
                    state_d = S_LAUNCH;
                end else if (blk_q == LAST_BLK) begin
                    state_d = S_FIN;
                end else begin
                    blk_d = blk_q + 3'd1;
                end
            end
            S_LAUNCH: begin
                if (dct_rdy) state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!dct_rdy) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (dct_rdy) begin
                    if (blk_q == LAST_BLK) begin
                        state_d = S_FIN;
                    end else begin
                        blk_d   = blk_q + 3'd1;
                        state_d = S_SEEK;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    logic       is_luma;
    logic [2:0] chroma_off;

    always_comb begin
        rdy      = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        mb_done  = (state_q == S_FIN);
        dct_en   = (state_q == S_LAUNCH) && dct_rdy;
        // Writes are only forwarded while a block is actually running.
        dst_wren = ((state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE)) && dct_wwren;

        is_luma    = (blk_q < LUMA_LAST);
        chroma_off = blk_q - LUMA_LAST;
        if (is_luma) begin
            // Block b sits at (row b[1], col b[0]) of the 2x2 luma tiling.
            src_addr = {1'b0, blk_q[1], dct_iaddr[5:3], blk_q[0], dct_iaddr[2:0]};
        end else begin
            src_addr = 9'd256 + {chroma_off, 6'd0} + {3'd0, dct_iaddr};
        end
        mat_addr  = {~is_luma, dct_maddr};
        dst_addr  = {blk_q, dct_waddr};
        blk_idx   = blk_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_dct_mb_sched.sv
module tb_dct_mb_sched;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       start = 1'b0;
  logic [5:0] blk_mask = 6'd0;
  logic       rdy, busy, mb_done, dct_en, dst_wren;
  logic [2:0] blk_idx, dbg_state;
  logic       dct_rdy, dct_wwren;
  logic [5:0] dct_iaddr = 6'd0;
  logic [5:0] dct_maddr = 6'd0;
  logic [5:0] dct_waddr;
  logic [8:0] src_addr, dst_addr;
  logic [6:0] mat_addr;

  dct_mb_sched dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .blk_mask  (blk_mask),
    .rdy       (rdy),
    .busy      (busy),
    .mb_done   (mb_done),
    .blk_idx   (blk_idx),
    .dct_rdy   (dct_rdy),
    .dct_en    (dct_en),
    .dct_iaddr (dct_iaddr),
    .dct_maddr (dct_maddr),
    .dct_waddr (dct_waddr),
    .dct_wwren (dct_wwren),
    .src_addr  (src_addr),
    .mat_addr  (mat_addr),
    .dst_addr  (dst_addr),
    .dst_wren  (dst_wren),
    .dbg_state (dbg_state)
  );

  // ---------------- dct2d behavioural model ----------------
  // Accepts en while idle, drops rdy, then writes waddr 0,21,42,63 and
  // returns to idle.
  logic       m_rdy, m_wwren;
  logic [2:0] m_cnt;
  logic [5:0] m_waddr;
  logic       m_stall = 1'b0;
  logic       force_wwren = 1'b0;

  assign dct_rdy   = m_rdy & ~m_stall;
  assign dct_wwren = m_wwren | force_wwren;
  assign dct_waddr = m_waddr;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_rdy <= 1'b1; m_cnt <= 3'd0; m_wwren <= 1'b0; m_waddr <= 6'd0;
    end else if (dct_en) begin
      m_rdy <= 1'b0; m_cnt <= 3'd4; m_wwren <= 1'b0;
    end else if (m_cnt != 3'd0) begin
      m_cnt   <= m_cnt - 3'd1;
      m_wwren <= 1'b1;
      m_waddr <= 6'((4 - int'(m_cnt)) * 21);
    end else begin
      m_wwren <= 1'b0;
      m_rdy   <= 1'b1;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0] en_q[$];
  int done_cnt = 0, wr_lo = 0, wr_hi = 0, wr_bad = 0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (dct_en) en_q.push_back(blk_idx);
      if (mb_done) done_cnt++;
      if (dst_wren) begin
        if (dst_addr <= 9'd63) wr_lo++;
        else if (dst_addr >= 9'd320 && dst_addr <= 9'd383) wr_hi++;
        else wr_bad++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [2:0] exp_q[$];
  int n_cmp = 0, n_bad = 0;
  int start_cyc = 0, done_at = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_en_seq(input string tag);
    logic [2:0] got;
    check({tag, "_en_count"}, en_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < en_q.size()) ? en_q[i] : 3'bxxx;
      check($sformatf("%s_en_blk%0d", tag, i), got, exp_q[i]);
    end
  endtask

  task automatic clear_logs();
    en_q.delete(); exp_q.delete();
    done_cnt = 0; wr_lo = 0; wr_hi = 0; wr_bad = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_mb(input logic [5:0] m, input bit hold);
    bit got = 1'b0;
    @(negedge clk);
    start = 1'b1; blk_mask = m; start_cyc = cyc;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (mb_done) begin got = 1'b1; done_at = cyc; start = 1'b0; break; end
    end
    check("run_done_seen", got, 1);
    @(negedge clk);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (mb_done) begin got = 1'b1; break; end
    end
    check("wait_done_seen", got, 1);
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;

    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_rdy", rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_mb_done", mb_done, 0);
    check("rst_dct_en", dct_en, 0);
    check("rst_blk_idx", blk_idx, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Idle address mapping on blk_idx=0: row 7 col 5 -> 7*16+5
    dct_iaddr = 6'o75; dct_maddr = 6'h2A;
    #1;
    check("idle_src", src_addr, 117);
    check("idle_mat", mat_addr, 7'h2A);
    check("idle_dst", dst_addr, 0);
    force_wwren = 1'b1;
    #1;
    check("idle_wren_gated", dst_wren, 0);
    force_wwren = 1'b0;

    // Full macroblock
    clear_logs();
    for (int i = 0; i < 6; i++) exp_q.push_back(3'(i));
    run_mb(6'h3F, 1'b0);
    check_en_seq("full");
    check("full_done_cnt", done_cnt, 1);
    check("full_rdy", rdy, 1);
    check("full_busy", busy, 0);
    check("full_writes_lo", wr_lo, 4);
    check("full_writes_hi", wr_hi, 4);

    // Luma block 3 mapping, with LAUNCH held off by dct_rdy=0
    clear_logs();
    m_stall = 1'b1;
    @(negedge clk); start = 1'b1; blk_mask = 6'h08;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dbg_state == 3'd2) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("b3_reach_launch", got, 1);
    check("b3_hold_en", dct_en, 0);
    @(negedge clk);
    check("b3_hold_state", dbg_state, 2);
    check("b3_hold_blk", blk_idx, 3);
    m_stall = 1'b0;
    #1;
    check("b3_en", dct_en, 1);
    check("b3_src", src_addr, 253);
    check("b3_mat", mat_addr, 7'h2A);
    wait_done();

    // Chroma block 5 mapping
    clear_logs();
    @(negedge clk); start = 1'b1; blk_mask = 6'h20;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dct_en) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("b5_en_seen", got, 1);
    check("b5_blk", blk_idx, 5);
    check("b5_src", src_addr, 381);
    check("b5_mat", mat_addr, 7'h6A);
    check("b5_dst", dst_addr, {3'd5, m_waddr});
    wait_done();

    // Sparse mask: blocks 0 and 5 only
    clear_logs();
    exp_q.push_back(3'd0); exp_q.push_back(3'd5);
    run_mb(6'h21, 1'b0);
    check_en_seq("sparse");
    check("sparse_wr_lo", wr_lo, 4);
    check("sparse_wr_hi", wr_hi, 4);
    check("sparse_wr_bad", wr_bad, 0);
    check("sparse_done_cnt", done_cnt, 1);

    // Empty mask: 6 SEEK cycles then FIN
    clear_logs();
    run_mb(6'h00, 1'b0);
    check("empty_latency", done_at - start_cyc, 7);
    check("empty_en_count", en_q.size(), 0);
    check("empty_done_cnt", done_cnt, 1);
    check("empty_blk_last", blk_idx, 5);

    // Reset while block 2 is in flight
    clear_logs();
    @(negedge clk); start = 1'b1; blk_mask = 6'h3F;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dct_en && blk_idx == 3'd2) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("abort_reach_blk2", got, 1);
    @(negedge clk);
    check("abort_pre_state", dbg_state, 3);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_state", dbg_state, 0);
    check("abort_rdy", rdy, 1);
    check("abort_dct_en", dct_en, 0);
    check("abort_busy", busy, 0);
    check("abort_blk", blk_idx, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // start held high through the whole macroblock and FIN
    clear_logs();
    run_mb(6'h01, 1'b1);
    repeat (5) @(negedge clk);
    check("hold_done_cnt", done_cnt, 1);
    check("hold_en_count", en_q.size(), 1);
    check("hold_busy", busy, 0);
    check("hold_rdy", rdy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
